// File: rtl/mux_sel_sequencer.sv
// Feeds an 8:1 select mux: holds one accepted byte on d and walks s through
// all eight codes, one per step, so the mux output Y streams the byte out.
module mux_sel_sequencer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       step,
  output logic [7:0] d,
  output logic [2:0] s,
  output logic       bit_valid,
  output logic       first,
  output logic       last
);

  localparam logic [2:0] START = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] END   = MSB_FIRST ? 3'd0 : 3'd7;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [2:0] sel_q, sel_d;
  logic       at_end, accept;

  assign at_end   = (sel_q == END);
  // The final step of a word doubles as the load slot for the next one.
  assign in_ready = rst_n & ((state_q == IDLE) | ((state_q == SHIFT) & at_end & step));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = in_data;
          sel_d   = START;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (step) begin
          if (!at_end) begin
            sel_d = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);
          end else if (accept) begin
            data_d = in_data;
            sel_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= 8'h00;
      sel_q   <= START;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign d         = data_q;
  assign s         = sel_q;
  assign bit_valid = (state_q == SHIFT);
  assign first     = bit_valid & (sel_q == START);
  assign last      = bit_valid & at_end;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: LSB-first and MSB-first instances share stimulus;
// a bit-index model is compared every cycle, plus literal expectations.
module tb_mux_sel_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       step = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       rdy[2];
  logic [7:0] dd[2];
  logic [2:0] ss[2];
  logic       bv[2], fst[2], lst[2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_sel_sequencer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .step(step), .d(dd[0]), .s(ss[0]),
    .bit_valid(bv[0]), .first(fst[0]), .last(lst[0]));

  mux_sel_sequencer #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .step(step), .d(dd[1]), .s(ss[1]),
    .bit_valid(bv[1]), .first(fst[1]), .last(lst[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Downstream mux: Y = d[s]
  function automatic logic yv(input int m);
    return dd[m][ss[m]];
  endfunction

  // Model: busy flag, held word, and how many bits of the word have gone by.
  logic       m_busy = 1'b0;
  logic [7:0] m_word = 8'h00;
  int         m_idx  = 0;

  function automatic logic m_ready();
    return !m_busy || (m_idx == 7 && step);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_word <= 8'h00;
      m_idx  <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_word <= in_data;
        m_idx  <= 0;
      end
    end else if (step) begin
      if (m_idx != 7) m_idx <= m_idx + 1;
      else if (in_valid) begin
        m_word <= in_data;
        m_idx  <= 0;
      end else m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("model_ready%0d", m), rdy[m], m_ready());
        chk($sformatf("model_bv%0d", m), bv[m], m_busy);
        chk($sformatf("model_d%0d", m), dd[m], m_word);
        chk($sformatf("model_s%0d", m), ss[m], (m == 0) ? m_idx : 7 - m_idx);
        chk($sformatf("model_first%0d", m), fst[m], m_busy && m_idx == 0);
        chk($sformatf("model_last%0d", m), lst[m], m_busy && m_idx == 7);
      end
    end
  end

  task automatic accept_word(input logic [7:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq;
    int nbv;
    // 1: reset with in_valid high
    in_valid = 1'b1; in_data = 8'hA5;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", rdy[0], 1'b0);
    chk("rst_bv", bv[0], 1'b0);
    chk("rst_d", dd[0], 8'h00);
    chk("rst_s_lsb", ss[0], 3'd0);
    chk("rst_s_msb", ss[1], 3'd7);
    @(posedge clk); #1;
    chk("rst_hold_bv", bv[0], 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_ready_lsb", rdy[0], 1'b1);
    chk("rel_ready_msb", rdy[1], 1'b1);
    step = 1'b1;

    // 2: single word, step held high
    accept_word(8'hA5);
    seq = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("w1_s", ss[0], i);
      chk("w1_y_lsb", yv(0), seq[7-i]);
      chk("w1_y_msb", yv(1), seq[7-i]);
      chk("w1_first", fst[0], i == 0);
      chk("w1_last", lst[0], i == 7);
    end
    @(negedge clk);
    chk("w1_idle", bv[0], 1'b0);

    // 3: back-to-back words
    in_valid = 1'b1; in_data = 8'h01;
    @(posedge clk); #1;
    in_data = 8'h80;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 8) in_valid = 1'b0;
      chk("b2b_bv", bv[0], 1'b1);
      chk("b2b_ready", rdy[0], (i % 8) == 7);
      chk("b2b_y", yv(0), (i == 0) || (i == 15));
    end
    @(negedge clk);
    chk("b2b_idle", bv[0], 1'b0);

    // 4: five-cycle stall at s=3
    accept_word(8'h3C);
    nbv = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (bv[0]) nbv++;
      if (n >= 3 && n <= 8) begin
        chk("stall_s", ss[0], 3'd3);
        chk("stall_d", dd[0], 8'h3C);
        chk("stall_bv", bv[0], 1'b1);
      end
      step = !(n >= 3 && n <= 7);
    end
    chk("stall_len", nbv, 13);

    // 4b: stall on the last bit blocks in_ready even with in_valid high
    accept_word(8'hC3);
    repeat (8) @(negedge clk);
    chk("laststall_s", ss[0], 3'd7);
    step = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
    repeat (2) begin
      @(negedge clk);
      chk("laststall_ready", rdy[0], 1'b0);
      chk("laststall_last", lst[0], 1'b1);
    end
    step = 1'b1;
    #1 chk("laststall_release", rdy[0], 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("laststall_idle", bv[0], 1'b0);
    chk("laststall_dhold", dd[0], 8'h5A);

    // 5: MSB-first instance on 8'h80
    accept_word(8'h80);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("msb_s", ss[1], 7 - i);
      chk("msb_y", yv(1), i == 0);
      chk("msb_first", fst[1], i == 0);
      chk("msb_last", lst[1], i == 7);
    end
    @(negedge clk);
    chk("msb_idle", bv[1], 1'b0);

    // 6: asynchronous reset mid-word
    accept_word(8'hFF);
    repeat (5) @(negedge clk);
    chk("mid_s", ss[0], 3'd4);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_bv", bv[0], 1'b0);
    chk("mid_d", dd[0], 8'h00);
    chk("mid_s_lsb", ss[0], 3'd0);
    chk("mid_s_msb", ss[1], 3'd7);
    chk("mid_ready", rdy[0], 1'b0);
    chk("mid_last", lst[0] | fst[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    accept_word(8'hFF);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("ff_y_lsb", yv(0), 1'b1);
      chk("ff_y_msb", yv(1), 1'b1);
    end
    @(negedge clk);
    chk("ff_idle", bv[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
